tlp_tx_scheduler: RTL and testbench

TLP_TX_SCHEDULER -- requirements
Module: tlp_tx_scheduler

---
 rtl/tlp_tx_scheduler.sv | 97 +++++++++
 tb/tb_tlp_tx_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tlp_tx_scheduler.sv
// TX-path arbiter between MWr and MRd requesters with NP flow-control credit tracking.
// Optional round-robin tie-break: define TX_ARB_ROUND_ROBIN_EN (default build is fixed MWr priority).
module tlp_tx_scheduler #(
    parameter int LIMIT_FC_MAX_NP = 18,
    parameter int TBUF_MIN        = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init_rst_i,
    input  logic       mwr_req_i,
    input  logic       mrd_req_i,
    input  logic       tlp_done_i,
    input  logic       cpl_done_i,
    input  logic [5:0] trn_tbuf_av_i,
    output logic       mwr_gnt_o,
    output logic       mrd_gnt_o,
    output logic [5:0] np_pending_o,
    output logic       busy_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GNT_MWR = 2'd1;
    localparam logic [1:0] GNT_MRD = 2'd2;

    localparam logic [5:0] NP_LIM = 6'(LIMIT_FC_MAX_NP);
    localparam logic [5:0] TB_MIN = 6'(TBUF_MIN);

    logic [1:0] state_q, state_d;
    logic [5:0] np_q, np_d;
    logic       mwr_elig, mrd_elig, pick_mrd;
    logic       soft_clr;

    assign soft_clr = !rst_n || init_rst_i;
    assign mwr_elig = mwr_req_i && (trn_tbuf_av_i >= TB_MIN);
    assign mrd_elig = mrd_req_i && (trn_tbuf_av_i >= TB_MIN) && (np_q < NP_LIM);

`ifdef TX_ARB_ROUND_ROBIN_EN
    // last_mrd_q: 1 when the most recent grant went to MRd
    logic last_mrd_q, last_mrd_d;

    always_comb begin
        pick_mrd   = mrd_elig && (!mwr_elig || !last_mrd_q);
        last_mrd_d = last_mrd_q;
        if (state_q == IDLE && (mwr_elig || mrd_elig))
            last_mrd_d = pick_mrd;
    end

    always_ff @(posedge clk) begin
        if (soft_clr) last_mrd_q <= 1'b1;
        else          last_mrd_q <= last_mrd_d;
    end
`else
    assign pick_mrd = mrd_elig && !mwr_elig;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_mrd)      state_d = GNT_MRD;
                else if (mwr_elig) state_d = GNT_MWR;
            end
            GNT_MWR, GNT_MRD: begin
                if (tlp_done_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Simultaneous issue and completion cancel, even at zero.
    always_comb begin
        logic inc;
        inc  = (state_q == IDLE) && (state_d == GNT_MRD);
        np_d = np_q;
        if (inc && !cpl_done_i)                     np_d = np_q + 6'd1;
        else if (!inc && cpl_done_i && np_q != '0)  np_d = np_q - 6'd1;
    end

    always_ff @(posedge clk) begin
        if (soft_clr) begin
            state_q      <= IDLE;
            np_q         <= '0;
            mwr_gnt_o    <= 1'b0;
            mrd_gnt_o    <= 1'b0;
            busy_o       <= 1'b0;
            np_pending_o <= '0;
        end else begin
            state_q      <= state_d;
            np_q         <= np_d;
            mwr_gnt_o    <= (state_d == GNT_MWR);
            mrd_gnt_o    <= (state_d == GNT_MRD);
            busy_o       <= (state_d != IDLE);
            np_pending_o <= np_d;
        end
    end

endmodule

// File: tb/tb_tlp_tx_scheduler.sv
// Bench for tlp_tx_scheduler: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an ownership/credit model.
module tb_tlp_tx_scheduler;

    localparam int LIM  = 4;
    localparam int TMIN = 2;
`ifdef TX_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, init_rst = 1'b0;
    logic       mwr_req = 1'b0, mrd_req = 1'b0, tlp_done = 1'b0, cpl_done = 1'b0;
    logic [5:0] tbuf = 6'd0;
    logic       mwr_gnt, mrd_gnt, busy;
    logic [5:0] np_pend;

    int vecs = 0;
    int errs = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    tlp_tx_scheduler #(.LIMIT_FC_MAX_NP(LIM), .TBUF_MIN(TMIN)) dut (
        .clk(clk), .rst_n(rst_n), .init_rst_i(init_rst),
        .mwr_req_i(mwr_req), .mrd_req_i(mrd_req),
        .tlp_done_i(tlp_done), .cpl_done_i(cpl_done),
        .trn_tbuf_av_i(tbuf),
        .mwr_gnt_o(mwr_gnt), .mrd_gnt_o(mrd_gnt),
        .np_pending_o(np_pend), .busy_o(busy)
    );

    // Model: owner 0 = none, 1 = MWr, 2 = MRd; last = owner of most recent grant.
    int m_own = 0, m_np = 0, m_last = 2;

    always @(posedge clk) begin
        int pick;
        bit inc, ok, we, re;
        if (!rst_n || init_rst) begin
            m_own = 0; m_np = 0; m_last = 2;
        end else begin
            inc = 0;
            if (m_own == 0) begin
                ok = (int'(tbuf) >= TMIN);
                we = mwr_req && ok;
                re = mrd_req && ok && (m_np < LIM);
                if (we && re)  pick = (RR && m_last == 1) ? 2 : 1;
                else if (we)   pick = 1;
                else if (re)   pick = 2;
                else           pick = 0;
                if (pick != 0) begin
                    m_own = pick; m_last = pick; inc = (pick == 2);
                end
            end else if (tlp_done) begin
                m_own = 0;
            end
            if (inc && cpl_done)          m_np = m_np;
            else if (inc)                 m_np = m_np + 1;
            else if (cpl_done && m_np > 0) m_np = m_np - 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            vecs++;
            if (mwr_gnt !== (m_own == 1) || mrd_gnt !== (m_own == 2) ||
                busy !== (m_own != 0) || int'(np_pend) != m_np || $isunknown(np_pend)) begin
                errs++;
                $display("FAIL model t=%0t: got mwr=%b mrd=%b busy=%b np=%0d, want owner=%0d np=%0d",
                         $time, mwr_gnt, mrd_gnt, busy, np_pend, m_own, m_np);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic soft_reset();
        init_rst = 1'b1; tick(); init_rst = 1'b0;
    endtask

    // Issue edge already done by caller; hold grant 3 cycles then release.
    task automatic finish_grant();
        tick(2);
        tlp_done = 1'b1; tick(); tlp_done = 1'b0;
    endtask

    initial begin
        int seq[4];
        tick(2);
        chk("reset_mwr_gnt", int'(mwr_gnt), 0);
        chk("reset_np", int'(np_pend), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1; tbuf = 6'd10; cmp_en = 1'b1;

        // basic grant
        mwr_req = 1'b1; tick(); mwr_req = 1'b0;
        chk("basic_gnt", int'(mwr_gnt), 1);
        chk("basic_busy", int'(busy), 1);
        tick(); chk("basic_hold", int'(mwr_gnt), 1);
        tlp_done = 1'b1; tick(); tlp_done = 1'b0;
        chk("basic_release", int'(mwr_gnt), 0);
        chk("basic_idle_busy", int'(busy), 0);

        // tie
        soft_reset();
        mwr_req = 1'b1; mrd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            seq[i] = mrd_gnt ? 2 : (mwr_gnt ? 1 : 0);
            finish_grant();
        end
        mwr_req = 1'b0; mrd_req = 1'b0;
        for (int i = 0; i < 4; i++)
            chk($sformatf("tie_grant%0d", i), seq[i], (RR && (i % 2 == 1)) ? 2 : 1);

        // NP limit
        soft_reset(); tick();
        mrd_req = 1'b1;
        for (int i = 0; i < LIM; i++) begin
            tick();
            chk($sformatf("np_grant%0d", i), int'(mrd_gnt), 1);
            chk($sformatf("np_cnt%0d", i), int'(np_pend), i + 1);
            finish_grant();
        end
        tick(3);
        chk("np_blocked", int'(mrd_gnt), 0);
        chk("np_at_limit", int'(np_pend), LIM);
        cpl_done = 1'b1; tick(); cpl_done = 1'b0;
        chk("np_after_cpl", int'(np_pend), LIM - 1);
        tick();
        chk("np_regrant", int'(mrd_gnt), 1);
        chk("np_refill", int'(np_pend), LIM);
        mrd_req = 1'b0;
        finish_grant();

        // buffer gating
        soft_reset();
        tbuf = 6'd1; mwr_req = 1'b1; mrd_req = 1'b1;
        tick(2);
        chk("tbuf_low_nogrant", int'(busy), 0);
        tbuf = 6'd2; tick();
        chk("tbuf_ok_grant", int'(mwr_gnt), 1);
        mwr_req = 1'b0; mrd_req = 1'b0; tbuf = 6'd0; tick();
        chk("tbuf_drop_hold", int'(mwr_gnt), 1);
        tlp_done = 1'b1; tick(); tlp_done = 1'b0;
        chk("tbuf_release", int'(busy), 0);
        tbuf = 6'd10;

        // boundaries
        soft_reset();
        mrd_req = 1'b1;
        for (int i = 0; i < 2; i++) begin tick(); mrd_req = 1'b0; finish_grant(); mrd_req = 1'b1; end
        chk("bnd_np2", int'(np_pend), 2);
        cpl_done = 1'b1; tick(); cpl_done = 1'b0; mrd_req = 1'b0;
        chk("bnd_coincident_gnt", int'(mrd_gnt), 1);
        chk("bnd_coincident_np", int'(np_pend), 2);
        finish_grant();
        soft_reset();
        cpl_done = 1'b1; tick(); cpl_done = 1'b0;
        chk("bnd_cpl_at_zero", int'(np_pend), 0);
        mrd_req = 1'b1; tick(); mrd_req = 1'b0;
        chk("bnd_pre_init_gnt", int'(mrd_gnt), 1);
        init_rst = 1'b1; tick(); init_rst = 1'b0;
        chk("bnd_init_gnt", int'(mrd_gnt), 0);
        chk("bnd_init_np", int'(np_pend), 0);
        chk("bnd_init_busy", int'(busy), 0);
        tick();
        chk("bnd_init_stays_idle", int'(busy), 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            mwr_req  = ($urandom_range(0, 99) < 50);
            mrd_req  = ($urandom_range(0, 99) < 60);
            tlp_done = ($urandom_range(0, 99) < 30);
            cpl_done = ($urandom_range(0, 99) < 15);
            tbuf     = 6'($urandom_range(0, 5));
            init_rst = ($urandom_range(0, 999) < 5);
            rst_n    = !($urandom_range(0, 999) < 3);
            tick();
        end
        rst_n = 1'b1; init_rst = 1'b0; tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
